// File: rtl/ti_s4_share_gen_if.sv
// Share-generator bus: seed control, unmasked nibble input handshake and
// 2-share output handshake toward the TI component-function stage.
interface ti_s4_share_gen_if;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_shares;
    logic        out_last;

    // Producer side: feeds nibbles and seeds, consumes shares.
    modport master (
        output seed_load, seed, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_shares, out_last
    );

    // Share generator side.
    modport slave (
        input  seed_load, seed, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_shares, out_last
    );
endinterface

// File: rtl/ti_s4_share_gen.sv
// 2-share Boolean masking of 4-bit nibbles. Share A is the low nibble of a
// 16-bit Fibonacci LFSR, share B is data ^ share A. One output register
// stage, block framing via out_last, and LFSR warm-up after reset/seeding.
module ti_s4_share_gen #(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned WARMUP_CYCLES = 8,
    parameter int unsigned BLOCK_LEN     = 16
) (
    input  logic               clk,
    input  logic               rst,
    ti_s4_share_gen_if.slave   bus
);

    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } state_e;

    localparam logic [7:0] WARM_INIT = 8'(WARMUP_CYCLES);
    localparam logic [7:0] LAST_IDX  = 8'(BLOCK_LEN - 1);

    state_e      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  blk_q, blk_d;
    logic        valid_q, valid_d;
    logic [7:0]  shares_q, shares_d;
    logic        last_q, last_d;

    logic        run;
    logic        warm_adv;
    logic        in_ready;
    logic        accept;

    // Four single LFSR steps, x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step4(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int unsigned i = 0; i < 4; i++) begin
            r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        end
        return r;
    endfunction

    // A WARMUP state whose counter has reached zero already behaves as RUN,
    // so WARMUP_CYCLES=0 accepts in the first cycle without an LFSR advance.
    assign run      = (state_q == ST_RUN) || (wcnt_q == '0);
    assign warm_adv = (state_q == ST_WARMUP) && (wcnt_q != '0);
    assign in_ready = !rst && !bus.seed_load && run && (!valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_shares = shares_q;
    assign bus.out_last   = last_q;

    // Next-state: seed load first, then warm-up stepping, then accept/transfer.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        lfsr_d   = lfsr_q;
        blk_d    = blk_q;
        valid_d  = valid_q;
        shares_d = shares_q;
        last_d   = last_q;

        if (bus.seed_load) begin
            lfsr_d  = (bus.seed == '0) ? LFSR_SEED : bus.seed;
            state_d = ST_WARMUP;
            wcnt_d  = WARM_INIT;
            blk_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (warm_adv) begin
                lfsr_d = lfsr_step4(lfsr_q);
                wcnt_d = wcnt_q - 8'd1;
            end
            if (run) begin
                state_d = ST_RUN;
            end
            if (accept) begin
                shares_d = {bus.in_data ^ lfsr_q[3:0], lfsr_q[3:0]};
                valid_d  = 1'b1;
                last_d   = (blk_q == LAST_IDX);
                blk_d    = (blk_q == LAST_IDX) ? '0 : blk_q + 8'd1;
                lfsr_d   = lfsr_step4(lfsr_q);
            end else if (bus.out_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_WARMUP;
            wcnt_q   <= WARM_INIT;
            lfsr_q   <= LFSR_SEED;
            blk_q    <= '0;
            valid_q  <= 1'b0;
            shares_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            lfsr_q   <= lfsr_d;
            blk_q    <= blk_d;
            valid_q  <= valid_d;
            shares_q <= shares_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_ti_s4_share_gen.sv
// Bench for ti_s4_share_gen: a zero-warm-up, 4-nibble-block instance driven
// against a scoreboard model, plus a default instance for warm-up timing.
module tb_ti_s4_share_gen;

    localparam int unsigned BL0 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ti_s4_share_gen_if if0 ();
    ti_s4_share_gen_if if8 ();

    ti_s4_share_gen #(.LFSR_SEED(16'hACE1), .WARMUP_CYCLES(0), .BLOCK_LEN(BL0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    ti_s4_share_gen u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] mask;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_lfsr;
    int unsigned m_idx;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_last;
    int unsigned n_acc;
    logic [15:0] masks_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Spec LFSR single step applied n times.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int unsigned n);
        logic [15:0] r;
        r = s;
        for (int unsigned i = 0; i < n; i++) begin
            r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        end
        return r;
    endfunction

    // One cycle on dut0: called at a falling edge, returns at the next one.
    task automatic cyc0(input logic vld, input logic [3:0] d, input logic ordy,
                        input logic sl, input logic [15:0] sd);
        logic exp_rdy;
        logic acc;
        exp_t e;
        if0.in_valid  = vld;
        if0.in_data   = d;
        if0.out_ready = ordy;
        if0.seed_load = sl;
        if0.seed      = sd;
        #1;
        exp_rdy = !sl && (exp_q.size() == 0 || ordy);
        chk("in_ready", {31'd0, if0.in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, if0.out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("share_a", {28'd0, if0.out_shares[3:0]}, {28'd0, e.mask});
            chk("share_xor", {28'd0, if0.out_shares[7:4] ^ if0.out_shares[3:0]}, {28'd0, e.data});
            chk("out_last", {31'd0, if0.out_last}, {31'd0, e.last});
            if (ordy && !sl) begin
                if (if0.out_last) n_last++;
                masks_seen[if0.out_shares[3:0]] = 1'b1;
                void'(exp_q.pop_front());
            end
        end
        acc = vld && exp_rdy;
        @(posedge clk);
        if (sl) begin
            m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
            m_idx  = 0;
            exp_q.delete();
        end else if (acc) begin
            e.data = d;
            e.mask = m_lfsr[3:0];
            e.last = ((m_idx % BL0) == BL0 - 1);
            exp_q.push_back(e);
            m_lfsr = lfsr_adv(m_lfsr, 4);
            m_idx++;
            n_acc++;
        end
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          lowcnt;
        int unsigned budget;
        logic [15:0] warm_state;

        m_lfsr = 16'hACE1;
        m_idx  = 0;
        n_acc  = 0;
        n_last = 0;
        masks_seen = '0;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
        if0.seed_load = 1'b0; if0.seed = '0;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.out_ready = 1'b0;
        if8.seed_load = 1'b0; if8.seed = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, if8.out_valid}, 32'd0);
        chk("rst_out_shares", {24'd0, if8.out_shares}, 32'd0);
        chk("rst_out_last", {31'd0, if8.out_last}, 32'd0);
        chk("rst_in_ready8", {31'd0, if8.in_ready}, 32'd0);
        chk("rst_in_ready0", {31'd0, if0.in_ready}, 32'd0);
        rst = 1'b0;

        // Default instance: in_ready low for exactly 8 cycles after release.
        lowcnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (if8.in_ready) break;
            lowcnt++;
            @(negedge clk);
        end
        chk("warmup_len", lowcnt, 8);
        @(negedge clk);
        repeat (5) @(negedge clk);
        if8.in_valid  = 1'b1;
        if8.in_data   = 4'h0;
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        warm_state = lfsr_adv(16'hACE1, 32);
        chk("warm_valid", {31'd0, if8.out_valid}, 32'd1);
        chk("warm_shares", {24'd0, if8.out_shares}, {24'd0, warm_state[3:0], warm_state[3:0]});
        chk("warm_last", {31'd0, if8.out_last}, 32'd0);

        // Seed 0x0001: A -> B1, 5 -> 50.
        cyc0(1'b0, 4'h0, 1'b1, 1'b1, 16'h0001);
        cyc0(1'b1, 4'hA, 1'b1, 1'b0, 16'h0000);
        chk("seed1_first", {24'd0, if0.out_shares}, 32'h0000_00B1);
        cyc0(1'b1, 4'h5, 1'b1, 1'b0, 16'h0000);
        chk("seed1_second", {24'd0, if0.out_shares}, 32'h0000_0050);
        cyc0(1'b0, 4'h0, 1'b1, 1'b0, 16'h0000);

        // Zero seed falls back to ACE1: 0 -> 11.
        cyc0(1'b0, 4'h0, 1'b1, 1'b1, 16'h0000);
        cyc0(1'b1, 4'h0, 1'b1, 1'b0, 16'h0000);
        chk("seed0_first", {24'd0, if0.out_shares}, 32'h0000_0011);
        cyc0(1'b0, 4'h0, 1'b1, 1'b0, 16'h0000);

        // Backpressure: 5 stalled cycles, then transfer + accept.
        cyc0(1'b1, 4'h9, 1'b1, 1'b0, 16'h0000);
        repeat (5) cyc0(1'b1, 4'($urandom), 1'b0, 1'b0, 16'h0000);
        cyc0(1'b1, 4'h2, 1'b1, 1'b0, 16'h0000);
        cyc0(1'b0, 4'h0, 1'b1, 1'b0, 16'h0000);

        // Block framing with a seed load after nibble 6.
        cyc0(1'b0, 4'h0, 1'b1, 1'b1, 16'h1234);
        n_last = 0;
        repeat (6) cyc0(1'b1, 4'($urandom), 1'b1, 1'b0, 16'h0000);
        cyc0(1'b0, 4'h0, 1'b0, 1'b1, 16'h5678);
        repeat (4) cyc0(1'b1, 4'($urandom), 1'b1, 1'b0, 16'h0000);
        cyc0(1'b0, 4'h0, 1'b1, 1'b0, 16'h0000);
        chk("block_last_count", n_last, 2);

        // Random stream of 1000 nibbles under random backpressure.
        masks_seen = '0;
        n_acc  = 0;
        budget = 0;
        while (n_acc < 1000 && budget < 20000) begin
            cyc0($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0,
                 1'b0, 16'h0000);
            budget++;
        end
        chk("random_accepts", n_acc, 1000);
        repeat (2) cyc0(1'b0, 4'h0, 1'b1, 1'b0, 16'h0000);
        chk("random_drained", exp_q.size(), 0);
        chk("mask_varies", {31'd0, $countones(masks_seen) > 1}, 32'd1);

        // Asynchronous reset with an output pending.
        cyc0(1'b1, 4'h7, 1'b0, 1'b0, 16'h0000);
        if0.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("async_out_shares", {24'd0, if0.out_shares}, 32'd0);
        chk("async_out_last", {31'd0, if0.out_last}, 32'd0);
        chk("async_in_ready", {31'd0, if0.in_ready}, 32'd0);
        m_lfsr = 16'hACE1;
        m_idx  = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc0(1'b1, 4'h3, 1'b1, 1'b0, 16'h0000);
        cyc0(1'b0, 4'h0, 1'b1, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
